// File: rtl/fetch_prefetch_buffer.sv
// ============================================================================
// fetch_prefetch_buffer
// Sequential instruction fetcher with a DEPTH-entry {pc, instr} prefetch FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [31:0]      fetch_pc_q,  fetch_pc_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];

    logic [31:0] redirect_pc_w;
    logic        push_w;
    logic        pop_w;

    assign redirect_pc_w = redirect_pc_i & 32'hFFFF_FFFC;

    // Redirect wins over both FIFO operations in the same cycle.
    assign push_w = (state_q == ST_WAIT) & imem_ack_i & ~redirect_i;
    assign pop_w  = (count_q != '0) & id_ready_i & ~redirect_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_w;
                end else if (count_q < FULL_CNT) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i && redirect_i) begin
                    fetch_pc_d = redirect_pc_w;
                    state_d    = ST_IDLE;
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_d < FULL_CNT) ? ST_WAIT : ST_IDLE;
                end else if (redirect_i) begin
                    // The memory still owes an ack for the old address.
                    drop_addr_d = fetch_pc_q;
                    fetch_pc_d  = redirect_pc_w;
                    state_d     = ST_DROP;
                end
            end
            ST_DROP: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc_w;
                end
                if (imem_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req_o  = (state_q == ST_WAIT) || (state_q == ST_DROP);
        imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
        id_valid_o  = (count_q != '0);
        id_instr_o  = instr_mem_q[rd_ptr_q];
        id_pc_o     = pc_mem_q[rd_ptr_q];
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_w) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push_w) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_buffer.sv
// ============================================================================
// tb_fetch_prefetch_buffer
// Directed self-checking bench for the fetch prefetch buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic zw;
    logic ack_force;
    int   vec;
    int   err;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h0000_0013;
    endfunction

    // Memory model: zero-wait when zw is set, otherwise acks only when forced.
    assign imem_ack_i   = imem_req_o & (zw | ack_force);
    assign imem_rdata_i = instr_of(imem_addr_o);

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i         (clk_i),
        .nrst_i        (nrst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        nrst_i        = 1'b0;
        zw            = 1'b0;
        ack_force     = 1'b0;
        id_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        step;
        step;
        nrst_i = 1'b1;
    endtask

    task automatic test_reset;
        nrst_i        = 1'b0;
        zw            = 1'b1;
        ack_force     = 1'b0;
        id_ready_i    = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        step;
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
        vec++; if (imem_addr_o !== RESET_PC) begin err++; $display("FAIL rst_addr: got %h want %h", imem_addr_o, RESET_PC); end
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL rst_valid: got %b want 0", id_valid_o); end
        vec++; if (id_instr_o !== 32'h0) begin err++; $display("FAIL rst_instr: got %h want 0", id_instr_o); end
        vec++; if (id_pc_o !== 32'h0) begin err++; $display("FAIL rst_pc: got %h want 0", id_pc_o); end
        nrst_i = 1'b1;
        #1;
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL rst_rel_req: got %b want 0", imem_req_o); end
        step;
        vec++; if (imem_req_o !== 1'b1) begin err++; $display("FAIL rst_first_req: got %b want 1", imem_req_o); end
        vec++; if (imem_addr_o !== RESET_PC) begin err++; $display("FAIL rst_first_addr: got %h want %h", imem_addr_o, RESET_PC); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        do_reset;
        zw         = 1'b1;
        id_ready_i = 1'b1;
        step;
        for (int k = 0; k < 8; k++) begin
            vec++; if (imem_req_o !== 1'b1) begin err++; $display("FAIL stream_req[%0d]: got %b want 1", k, imem_req_o); end
            vec++; if (imem_addr_o !== 32'(4 * k)) begin err++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr_o, 32'(4 * k)); end
            if (k == 0) begin
                vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL stream_valid0: got %b want 0", id_valid_o); end
            end else begin
                exp_pc = 32'(4 * (k - 1));
                vec++; if (id_valid_o !== 1'b1) begin err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, id_valid_o); end
                vec++; if (id_pc_o !== exp_pc) begin err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, id_pc_o, exp_pc); end
                vec++; if (id_instr_o !== instr_of(exp_pc)) begin err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, id_instr_o, instr_of(exp_pc)); end
            end
            step;
        end
    endtask

    task automatic test_fill_drain;
        int          pushes;
        logic [31:0] exp_pcs [5];
        exp_pcs = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        do_reset;
        zw         = 1'b1;
        id_ready_i = 1'b0;
        step;
        pushes = 0;
        for (int c = 0; c < 6; c++) begin
            if (imem_req_o && imem_ack_i) pushes++;
            step;
        end
        vec++; if (pushes !== 4) begin err++; $display("FAIL fill_pushes: got %0d want 4", pushes); end
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL fill_req: got %b want 0", imem_req_o); end
        vec++; if (imem_addr_o !== 32'h10) begin err++; $display("FAIL fill_addr: got %h want 00000010", imem_addr_o); end
        vec++; if (id_valid_o !== 1'b1) begin err++; $display("FAIL fill_valid: got %b want 1", id_valid_o); end
        vec++; if (id_pc_o !== 32'h0) begin err++; $display("FAIL fill_head: got %h want 0", id_pc_o); end
        id_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step;
            vec++; if (id_pc_o !== exp_pcs[c]) begin err++; $display("FAIL drain_pc[%0d]: got %h want %h", c, id_pc_o, exp_pcs[c]); end
            vec++; if (id_instr_o !== instr_of(exp_pcs[c])) begin err++; $display("FAIL drain_instr[%0d]: got %h want %h", c, id_instr_o, instr_of(exp_pcs[c])); end
            if (c == 0) begin
                vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL drain_req0: got %b want 0", imem_req_o); end
            end
            if (c == 1) begin
                vec++; if (imem_req_o !== 1'b1) begin err++; $display("FAIL drain_req1: got %b want 1", imem_req_o); end
                vec++; if (imem_addr_o !== 32'h10) begin err++; $display("FAIL drain_addr: got %h want 00000010", imem_addr_o); end
            end
        end
    endtask

    task automatic test_wait_states;
        do_reset;
        id_ready_i = 1'b1;
        step;
        ack_force = 1'b1;
        step;
        ack_force = 1'b0;
        vec++; if (id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin err++; $display("FAIL ws_first: got v=%b pc=%h want v=1 pc=0", id_valid_o, id_pc_o); end
        for (int c = 0; c < 4; c++) begin
            vec++; if (imem_req_o !== 1'b1) begin err++; $display("FAIL ws_req[%0d]: got %b want 1", c, imem_req_o); end
            vec++; if (imem_addr_o !== 32'h4) begin err++; $display("FAIL ws_addr[%0d]: got %h want 00000004", c, imem_addr_o); end
            if (c > 0) begin
                vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL ws_empty[%0d]: got %b want 0", c, id_valid_o); end
            end
            if (c == 3) ack_force = 1'b1;
            step;
        end
        ack_force = 1'b0;
        vec++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h4) begin err++; $display("FAIL ws_push: got v=%b pc=%h want v=1 pc=4", id_valid_o, id_pc_o); end
        vec++; if (id_instr_o !== instr_of(32'h4)) begin err++; $display("FAIL ws_instr: got %h want %h", id_instr_o, instr_of(32'h4)); end
        vec++; if (imem_addr_o !== 32'h8) begin err++; $display("FAIL ws_next_addr: got %h want 00000008", imem_addr_o); end
        step;
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL ws_single: got %b want 0", id_valid_o); end
    endtask

    task automatic test_redirect_pending;
        do_reset;
        id_ready_i = 1'b1;
        step;
        ack_force = 1'b1;
        step;
        step;
        ack_force     = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        vec++; if (imem_addr_o !== 32'h8 || id_valid_o !== 1'b1) begin err++; $display("FAIL rp_pre: got addr=%h v=%b want addr=8 v=1", imem_addr_o, id_valid_o); end
        step;
        redirect_i = 1'b0;
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL rp_flush: got %b want 0", id_valid_o); end
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin err++; $display("FAIL rp_hold1: got req=%b addr=%h want req=1 addr=8", imem_req_o, imem_addr_o); end
        step;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin err++; $display("FAIL rp_hold2: got req=%b addr=%h want req=1 addr=8", imem_req_o, imem_addr_o); end
        ack_force = 1'b1;
        step;
        ack_force = 1'b0;
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL rp_discard: got %b want 0", id_valid_o); end
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL rp_idle: got %b want 0", imem_req_o); end
        step;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin err++; $display("FAIL rp_new_req: got req=%b addr=%h want req=1 addr=100", imem_req_o, imem_addr_o); end
        ack_force = 1'b1;
        step;
        ack_force = 1'b0;
        vec++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h100) begin err++; $display("FAIL rp_first_pc: got v=%b pc=%h want v=1 pc=100", id_valid_o, id_pc_o); end
        vec++; if (id_instr_o !== instr_of(32'h100)) begin err++; $display("FAIL rp_first_instr: got %h want %h", id_instr_o, instr_of(32'h100)); end
    endtask

    task automatic test_redirect_ack;
        do_reset;
        zw         = 1'b1;
        id_ready_i = 1'b1;
        step;
        step;
        vec++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin err++; $display("FAIL ra_pre: got v=%b pc=%h want v=1 pc=0", id_valid_o, id_pc_o); end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        step;
        redirect_i = 1'b0;
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL ra_flush: got %b want 0", id_valid_o); end
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL ra_idle: got %b want 0", imem_req_o); end
        vec++; if (imem_addr_o !== 32'h200) begin err++; $display("FAIL ra_align: got %h want 00000200", imem_addr_o); end
        step;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin err++; $display("FAIL ra_req: got req=%b addr=%h want req=1 addr=200", imem_req_o, imem_addr_o); end
        step;
        vec++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h200) begin err++; $display("FAIL ra_first_pc: got v=%b pc=%h want v=1 pc=200", id_valid_o, id_pc_o); end
    endtask

    task automatic test_async_reset;
        do_reset;
        zw         = 1'b1;
        id_ready_i = 1'b0;
        step;
        step;
        step;
        step;
        zw = 1'b0;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC || id_valid_o !== 1'b1) begin err++; $display("FAIL ar_pre: got req=%b addr=%h v=%b want req=1 addr=c v=1", imem_req_o, imem_addr_o, id_valid_o); end
        nrst_i = 1'b0;
        #1;
        vec++; if (imem_req_o !== 1'b0) begin err++; $display("FAIL ar_req: got %b want 0", imem_req_o); end
        vec++; if (imem_addr_o !== RESET_PC) begin err++; $display("FAIL ar_addr: got %h want %h", imem_addr_o, RESET_PC); end
        vec++; if (id_valid_o !== 1'b0) begin err++; $display("FAIL ar_valid: got %b want 0", id_valid_o); end
        vec++; if (id_instr_o !== 32'h0 || id_pc_o !== 32'h0) begin err++; $display("FAIL ar_head: got instr=%h pc=%h want 0 0", id_instr_o, id_pc_o); end
        step;
        nrst_i = 1'b1;
        zw     = 1'b1;
        step;
        vec++; if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC) begin err++; $display("FAIL ar_restart: got req=%b addr=%h want req=1 addr=%h", imem_req_o, imem_addr_o, RESET_PC); end
        step;
        vec++; if (id_valid_o !== 1'b1 || id_pc_o !== RESET_PC) begin err++; $display("FAIL ar_first_pc: got v=%b pc=%h want v=1 pc=%h", id_valid_o, id_pc_o, RESET_PC); end
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset;
        test_stream;
        test_fill_drain;
        test_wait_states;
        test_redirect_pending;
        test_redirect_ack;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

`default_nettype wire
